if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage. It is the producer side of the IF/ID pipeline-register interface.
- Holds the PC and issues word requests to instruction memory over a req/ready handshake.
- Drives the IF/ID inputs: current PC, PC+4, instruction word, jump flag.
- Applies hazard stalls, and redirects on taken branches (EX) and jumps (ID), with a one-entry skid buffer and drain handling.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (low 2 bits forced 0)
JUMP_OPC, 6'b000010, opcode of j
JAL_OPC, 6'b000011, opcode of jal

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset
imem_req  output  1  instruction memory request
imem_addr  output  32  request word address (= pc)
imem_ready  input  1  memory accepts request and returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_req && imem_ready
stall  input  1  hazard unit freezes the IF/ID inputs
branch_taken  input  1  taken branch from EX
branch_target  input  32  branch destination
jump_taken  input  1  jump resolved in ID
jump_address  input  26  instr[25:0] from ID
id_pc  input  32  PC of the jump instruction in ID
currpc  output  32  PC of the delivered instruction
nextpc  output  32  currpc + 4
inp_instn  output  32  delivered instruction
jump_in  output  1  inp_instn[31:26] equals JUMP_OPC or JAL_OPC
if_valid  output  1  delivered instruction is real (0 = bubble)

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc=RESET_PC, state=REQ.
  - currpc, nextpc, inp_instn and jump_in = 0; if_valid=0.
  - imem_req=0 while reset is low.
  - The first request, addr=RESET_PC, is issued the cycle after reset goes high.
  - Reset mid-operation aborts any request and empties the skid buffer.
- Redirect:
  - redirect = branch_taken | jump_taken. branch_taken has priority (older instruction).
  - Jump target = {id_pc[31:28], jump_address, 2'b00}.
  - Branch target = {branch_target[31:2], 2'b00}.
  - Every redirect sets if_valid<=0 next cycle, even when stall=1 (flush).
- Delivering a word to the outputs loads:
  - currpc=fetch pc, nextpc=fetch pc+4 (mod 2^32; 0xFFFFFFFC wraps to 0x0);
  - inp_instn=word, jump_in=opcode match, if_valid=1.
- Handshake rules:
  - Once imem_req is asserted, it and imem_addr stay stable until imem_ready, regardless of stall or redirect.
  - There is at most one outstanding request.
- FSM state REQ (imem_req=1, imem_addr=pc):
  - ready & redirect: discard word; pc=target; stay REQ.
  - ready & !stall: deliver word (latency 1 cycle, ready to outputs); pc+=4; stay REQ. Back-to-back throughput is 1 instr/cycle.
  - ready & stall: word, pc and jump flag go into the skid buffer; pc+=4; go to SKID. Outputs are held.
  - !ready & redirect: save target as pending; go to DRAIN.
  - !ready: stay. If !stall, if_valid<=0 (bubble). If stall, outputs are held.
- FSM state SKID (imem_req=0):
  - redirect: drop skid; pc=target; go to REQ.
  - !stall: deliver skid contents; go to REQ.
  - stall: hold.
- FSM state DRAIN (imem_req=1, addr=old pc):
  - A further redirect overwrites pending (latest wins; branch over jump in the same cycle).
  - On ready: discard word; pc=pending, or a same-cycle redirect target if one is present; go to REQ.
  - if_valid stays 0.
- Stall with no delivery in the same cycle: all outputs are held, including if_valid.

Test Plan:
1. Reset then imem_ready=1 constant, stall=0, memory at 0x0,0x4,0x8 = 0x20080005,0x08000010,0x00000000 -> successive cycles show currpc 0x0,0x4,0x8; nextpc 0x4,0x8,0xC; jump_in 0,1,0; if_valid=1.
2. stall=1 for 3 cycles when currpc=0x4 -> outputs held, one word captured to skid, imem_req=0. After release, 0x8 is delivered next cycle, then fetch resumes at 0xC with no lost or duplicated PC.
3. jump_taken with id_pc=0x1000_0040, jump_address=26'h0000100 -> next imem_addr=0x1000_0400; if_valid=0 one cycle; then currpc=0x1000_0400.
4. imem_ready held 0 for 2 cycles while branch_taken arrives (target 0x200) in the first of them -> imem_addr stays at the old pc until ready; that word is discarded; the next request is 0x200.
5. Same-cycle branch_taken (0x300) and jump_taken (any) with stall=1 -> pc=0x300, if_valid=0 despite stall.
6. pc=0xFFFFFFFC fetched -> nextpc=0x0, the following request is address 0x0; then assert reset low mid-request -> the cycle after reset releases, imem_req=1 at RESET_PC and all outputs read 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests instruction words from
// memory over a req/ready handshake and drives the IF/ID pipeline inputs.
// A one-entry skid buffer absorbs a word returned during a stall, and a
// drain state lets an outstanding request finish before a redirect applies.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  JUMP_OPC = 6'b000010,
    parameter logic [5:0]  JAL_OPC  = 6'b000011
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [25:0] jump_address,
    input  logic [31:0] id_pc,
    output logic [31:0] currpc,
    output logic [31:0] nextpc,
    output logic [31:0] inp_instn,
    output logic        jump_in,
    output logic        if_valid
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_SKID  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    // Opcode match for j / jal.
    function automatic logic is_jump(input logic [31:0] word);
        return (word[31:26] == JUMP_OPC) || (word[31:26] == JAL_OPC);
    endfunction

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] skid_instn_q, skid_instn_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_jump_q, skid_jump_d;
    logic [31:0] currpc_q, currpc_d;
    logic [31:0] nextpc_q, nextpc_d;
    logic [31:0] instn_q, instn_d;
    logic        jump_q, jump_d;
    logic        valid_q, valid_d;

    logic        redirect_s;
    logic [31:0] target_s;
    logic        accept_s;
    logic        unused_s;

    // Redirect target selection: the branch (older instruction) beats the jump.
    always_comb begin
        redirect_s = branch_taken | jump_taken;
        accept_s   = req_q & imem_ready;
        if (branch_taken) begin
            target_s = {branch_target[31:2], 2'b00};
        end else begin
            target_s = {id_pc[31:28], jump_address, 2'b00};
        end
    end

    // Word-alignment bits of the branch target and low id_pc bits are ignored.
    assign unused_s = ^{branch_target[1:0], id_pc[27:0]};

    // Fetch FSM next-state, PC, skid buffer and IF/ID output logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        skid_instn_d = skid_instn_q;
        skid_pc_d    = skid_pc_q;
        skid_jump_d  = skid_jump_q;
        currpc_d     = currpc_q;
        nextpc_d     = nextpc_q;
        instn_d      = instn_q;
        jump_d       = jump_q;
        valid_d      = valid_q;

        case (state_q)
            ST_REQ: begin
                if (accept_s) begin
                    if (redirect_s) begin
                        // Returned word is on the wrong path: drop it.
                        pc_d    = target_s;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        currpc_d = pc_q;
                        nextpc_d = pc_q + 32'd4;
                        instn_d  = imem_rdata;
                        jump_d   = is_jump(imem_rdata);
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end else begin
                        // Park the word; outputs stay frozen for the stall.
                        skid_instn_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_jump_d  = is_jump(imem_rdata);
                        pc_d         = pc_q + 32'd4;
                        state_d      = ST_SKID;
                    end
                end else if (redirect_s) begin
                    valid_d = 1'b0;
                    if (req_q) begin
                        // Request in flight: must finish at the old address.
                        pend_d  = target_s;
                        state_d = ST_DRAIN;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_SKID: begin
                if (redirect_s) begin
                    pc_d    = target_s;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    currpc_d = skid_pc_q;
                    nextpc_d = skid_pc_q + 32'd4;
                    instn_d  = skid_instn_q;
                    jump_d   = skid_jump_q;
                    valid_d  = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_SKID;
                end
            end
            ST_DRAIN: begin
                valid_d = 1'b0;
                if (redirect_s) begin
                    pend_d = target_s;
                end else begin
                    pend_d = pend_q;
                end
                if (accept_s) begin
                    if (redirect_s) begin
                        pc_d = target_s;
                    end else begin
                        pc_d = pend_q;
                    end
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_REQ;
                valid_d = 1'b0;
            end
        endcase

        req_d = (state_d != ST_SKID);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_REQ;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC_AL;
            pend_q       <= 32'd0;
            skid_instn_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            skid_jump_q  <= 1'b0;
            currpc_q     <= 32'd0;
            nextpc_q     <= 32'd0;
            instn_q      <= 32'd0;
            jump_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            skid_instn_q <= skid_instn_d;
            skid_pc_q    <= skid_pc_d;
            skid_jump_q  <= skid_jump_d;
            currpc_q     <= currpc_d;
            nextpc_q     <= nextpc_d;
            instn_q      <= instn_d;
            jump_q       <= jump_d;
            valid_q      <= valid_d;
        end
    end

    // Request is suppressed for as long as reset is held low.
    assign imem_req  = req_q & reset;
    assign imem_addr = pc_q;
    assign currpc    = currpc_q;
    assign nextpc    = nextpc_q;
    assign inp_instn = instn_q;
    assign jump_in   = jump_q;
    assign if_valid  = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural fetch model.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_taken;
    logic [25:0] jump_address;
    logic [31:0] id_pc;
    logic [31:0] currpc;
    logic [31:0] nextpc;
    logic [31:0] inp_instn;
    logic        jump_in;
    logic        if_valid;

    int total;
    int bad;

    // Behavioural model: next fetch address, request presence, parked word,
    // pending redirect, and the values last delivered to IF/ID.
    logic [31:0] m_pc;
    logic        m_fresh;
    logic        m_skid;
    logic [31:0] m_skw;
    logic [31:0] m_skpc;
    logic        m_drain;
    logic [31:0] m_pend;
    logic [31:0] m_cur;
    logic [31:0] m_nxt;
    logic [31:0] m_ins;
    logic        m_val;

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_taken   (jump_taken),
        .jump_address (jump_address),
        .id_pc        (id_pc),
        .currpc       (currpc),
        .nextpc       (nextpc),
        .inp_instn    (inp_instn),
        .jump_in      (jump_in),
        .if_valid     (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        logic [5:0]  opc;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        case (a[4:2])
            3'd1:    opc = 6'b000010;
            3'd2:    opc = 6'b000011;
            default: opc = w[31:26];
        endcase
        w = {opc, w[25:0]};
        if (a == 32'h0) w = 32'h2008_0005;
        if (a == 32'h4) w = 32'h0800_0010;
        if (a == 32'h8) w = 32'h0000_0000;
        return w;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] ins;
        logic        exp_j;
        logic        exp_req;
        ins     = m_ins;
        exp_j   = (ins[31:26] == 6'b000010) || (ins[31:26] == 6'b000011);
        exp_req = !m_fresh && !m_skid;
        chk_val("currpc", currpc, m_cur);
        chk_val("nextpc", nextpc, m_nxt);
        chk_val("inp_instn", inp_instn, m_ins);
        chk_val("jump_in", {31'd0, jump_in}, {31'd0, exp_j});
        chk_val("if_valid", {31'd0, if_valid}, {31'd0, m_val});
        chk_val("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk_val("imem_addr", imem_addr, m_pc);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        logic        req;
        logic        acc;
        if (!reset) begin
            m_pc = 32'h0; m_fresh = 1'b1; m_skid = 1'b0; m_drain = 1'b0;
            m_cur = 32'h0; m_nxt = 32'h0; m_ins = 32'h0; m_val = 1'b0;
            return;
        end
        redir = branch_taken || jump_taken;
        tgt   = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                             : {id_pc[31:28], jump_address, 2'b00};
        req   = !m_fresh && !m_skid;
        acc   = req && imem_ready;
        if (m_skid) begin
            if (redir) begin
                m_skid = 1'b0; m_pc = tgt; m_val = 1'b0;
            end else if (!stall) begin
                m_skid = 1'b0;
                m_cur = m_skpc; m_nxt = m_skpc + 32'd4; m_ins = m_skw; m_val = 1'b1;
            end
        end else if (m_drain) begin
            m_val = 1'b0;
            if (redir) m_pend = tgt;
            if (acc) begin
                m_pc = m_pend; m_drain = 1'b0;
            end
        end else if (acc) begin
            if (redir) begin
                m_pc = tgt; m_val = 1'b0;
            end else if (!stall) begin
                m_cur = m_pc; m_nxt = m_pc + 32'd4; m_ins = imem_rdata; m_val = 1'b1;
                m_pc = m_pc + 32'd4;
            end else begin
                m_skid = 1'b1; m_skw = imem_rdata; m_skpc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (redir) begin
                if (req) begin
                    m_drain = 1'b1; m_pend = tgt;
                end else begin
                    m_pc = tgt;
                end
            end
            if (redir || !stall) m_val = 1'b0;
        end
        m_fresh = 1'b0;
    endtask

    // One clock: apply inputs (after negedge), step model, check at next negedge.
    task automatic cyc(input logic r, input logic rdy, input logic st,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [25:0] ja, input logic [31:0] ip);
        reset = r; imem_ready = rdy; stall = st;
        branch_taken = b; branch_target = bt;
        jump_taken = j; jump_address = ja; id_pc = ip;
        imem_rdata = memf(imem_addr);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        total = 0; bad = 0;
        m_pc = 32'h0; m_fresh = 1'b1; m_skid = 1'b0; m_skw = 32'h0; m_skpc = 32'h0;
        m_drain = 1'b0; m_pend = 32'h0;
        m_cur = 32'h0; m_nxt = 32'h0; m_ins = 32'h0; m_val = 1'b0;
        reset = 1'b0; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump_taken = 1'b0; jump_address = 26'h0;
        id_pc = 32'h0; imem_rdata = 32'h0;
        @(negedge clk);

        // Reset state
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("rst_req", {31'd0, imem_req}, 32'd0);
        chk_val("rst_valid", {31'd0, if_valid}, 32'd0);

        // Straight-line fetch from 0x0
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("first_addr", imem_addr, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t1_pc0", currpc, 32'h0);
        chk_val("t1_jmp0", {31'd0, jump_in}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t1_pc4", currpc, 32'h4);
        chk_val("t1_jmp4", {31'd0, jump_in}, 32'd1);

        // Stall for three cycles with currpc=0x4
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
            chk_val("t2_hold", currpc, 32'h4);
            chk_val("t2_noreq", {31'd0, imem_req}, 32'd0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t2_pc8", currpc, 32'h8);
        chk_val("t2_npc8", nextpc, 32'hC);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t2_pcC", currpc, 32'hC);

        // Jump redirect
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h0000100, 32'h1000_0040);
        chk_val("t3_addr", imem_addr, 32'h1000_0400);
        chk_val("t3_bubble", {31'd0, if_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t3_pc", currpc, 32'h1000_0400);

        // Branch while memory is not ready: drain the old request
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 26'h0, 32'h0);
        chk_val("t4_hold_addr", imem_addr, 32'h1000_0404);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t4_hold_addr2", imem_addr, 32'h1000_0404);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t4_new_addr", imem_addr, 32'h0000_0200);
        chk_val("t4_discard", {31'd0, if_valid}, 32'd0);

        // Branch and jump together under stall
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0301, 1'b1, 26'h3FF_FFFF, 32'hF000_0000);
        chk_val("t5_addr", imem_addr, 32'h0000_0300);
        chk_val("t5_flush", {31'd0, if_valid}, 32'd0);

        // Wrap at the top of the address space, then reset mid-request
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t6_pc", currpc, 32'hFFFF_FFFC);
        chk_val("t6_npc_wrap", nextpc, 32'h0);
        chk_val("t6_addr_wrap", imem_addr, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t6_rst_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0);
        chk_val("t6_req_after", {31'd0, imem_req}, 32'd1);
        chk_val("t6_addr_after", imem_addr, 32'h0);
        chk_val("t6_cur_zero", currpc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic        r, rdy, st, b, j;
            logic [31:0] bt, ip;
            logic [25:0] ja;
            r   = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            st  = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 11) == 0);
            j   = ($urandom_range(0, 11) == 0);
            bt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            ja  = 26'($urandom);
            ip  = $urandom;
            cyc(r, rdy, st, b, bt, j, ja, ip);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
